// File: rtl/matrix_stream_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_stream_fetch_if                                     |
// | Description : Command / status / output-stream bundle for the matrix     |
// |               operand fetcher. master = command issuer and vector        |
// |               consumer, slave = the fetcher itself.                      |
// |               MATRIX_FETCH_STALL_CNT_EN adds the stall_cycles status.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface matrix_stream_fetch_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14,
    parameter int LANES      = 4
);
    logic                          start;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic [ADDR_WIDTH-1:0]         stride;
    logic [ADDR_WIDTH-1:0]         count;
    logic                          abort;
    logic                          busy;
    logic                          done;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*DATA_WIDTH-1:0]   out_data;
    logic                          out_last;
`ifdef MATRIX_FETCH_STALL_CNT_EN
    logic [31:0]                   stall_cycles;

    modport master (
        output start, base_addr, stride, count, abort, out_ready,
        input  busy, done, out_valid, out_data, out_last, stall_cycles
    );
    modport slave (
        input  start, base_addr, stride, count, abort, out_ready,
        output busy, done, out_valid, out_data, out_last, stall_cycles
    );
`else
    modport master (
        output start, base_addr, stride, count, abort, out_ready,
        input  busy, done, out_valid, out_data, out_last
    );
    modport slave (
        input  start, base_addr, stride, count, abort, out_ready,
        output busy, done, out_valid, out_data, out_last
    );
`endif
endinterface
`default_nettype wire

// File: rtl/matrix_stream_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_stream_fetch (+ romA lane ROM)                      |
// | Description : Multi-lane strided matrix operand fetcher. Walks the lane  |
// |               ROMs from base_addr by stride, streaming LANES-wide        |
// |               vectors through a credit-controlled output FIFO.           |
// |               Optional: MATRIX_FETCH_STALL_CNT_EN adds a saturating      |
// |               output stall-cycle counter (stall_cycles).                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// Single-port lane ROM, content mem[i] = i mod 2**DW, LAT-cycle read.
module romA #(
    parameter int DW  = 8,
    parameter int AW  = 14,
    parameter int LAT = 1
) (
    input  wire logic          clock,
    input  wire logic [AW-1:0] addr,
    output logic      [DW-1:0] q
);
    logic [AW+DW-1:0] w_word;
    logic             w_unused_hi;
    logic [DW-1:0]    r_q [LAT];

    assign w_word      = {{DW{1'b0}}, addr};
    assign w_unused_hi = ^w_word[AW+DW-1:DW];

    // Read pipeline: stage 0 samples the table, later stages add latency.
    always_ff @(posedge clock) begin
        r_q[0] <= w_word[DW-1:0];
        for (int i = 1; i < LAT; i++) begin
            r_q[i] <= r_q[i-1];
        end
    end

    assign q = r_q[LAT-1];
endmodule

module matrix_stream_fetch #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 14,
    parameter int LANES       = 4,
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    matrix_stream_fetch_if.slave    bus
);
    localparam int VEC_W = LANES * DATA_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 2);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  r_stride;
    logic [ADDR_WIDTH-1:0]  r_remaining;
    logic [ROM_LATENCY-1:0] r_pipe_vld;
    logic [ROM_LATENCY-1:0] r_pipe_last;
    logic [VEC_W-1:0]       w_rom_q;
    logic [VEC_W:0]         r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_fifo_cnt;
    logic [OCC_W-1:0]       w_inflight;
    logic [OCC_W-1:0]       w_occ;
    logic [VEC_W:0]         w_head;
    logic                   w_accept;
    logic                   w_flush;
    logic                   w_issue;
    logic                   w_last_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_out_valid;

    // abort beats a simultaneous start; in IDLE there is nothing to flush.
    assign w_accept     = (r_state == c_idle) && bus.start && !bus.abort;
    assign w_flush      = bus.abort && (r_state != c_idle);
    assign w_push       = r_pipe_vld[ROM_LATENCY-1];
    assign w_out_valid  = (r_fifo_cnt != '0);
    assign w_pop        = w_out_valid && bus.out_ready;
    assign w_last_issue = (r_remaining == ADDR_WIDTH'(1));

    // Count reads still travelling through the ROM pipeline.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + OCC_W'(r_pipe_vld[i]);
        end
    end

    // Every read reserves a FIFO slot at issue time, so the FIFO cannot overflow.
    assign w_occ   = w_inflight + OCC_W'(r_fifo_cnt) - OCC_W'(w_pop);
    assign w_issue = (r_state == c_issue) && !w_flush && (w_occ < OCC_W'(FIFO_DEPTH));

    // One ROM per lane; lane l reads the element l past the vector address.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ADDR_WIDTH-1:0] w_lane_addr;
        assign w_lane_addr = r_addr + ADDR_WIDTH'(l);
        romA #(
            .DW  (DATA_WIDTH),
            .AW  (ADDR_WIDTH),
            .LAT (ROM_LATENCY)
        ) u_rom (
            .clock (clock),
            .addr  (w_lane_addr),
            .q     (w_rom_q[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Command sequencing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_state_nxt = (bus.count == '0) ? c_done : c_issue;
            c_issue: if (w_issue && w_last_issue) w_state_nxt = c_drain;
            c_drain: if (w_inflight == '0 && r_fifo_cnt == '0) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
        if (w_flush) w_state_nxt = c_idle;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= c_idle;
        else          r_state <= w_state_nxt;
    end

    // Address walker: load on accepted start, advance by stride per issued read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_addr      <= bus.base_addr;
            r_stride    <= bus.stride;
            r_remaining <= bus.count;
        end else if (w_issue) begin
            r_addr      <= r_addr + r_stride;
            r_remaining <= r_remaining - ADDR_WIDTH'(1);
        end
    end

    // Valid/last tags travelling alongside the ROM read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else if (w_flush) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_vld[0]  <= w_issue;
            r_pipe_last[0] <= w_issue && w_last_issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any fill level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // FIFO storage: {last, vector}; no reset needed, outputs are gated by valid.
    always_ff @(posedge clock) begin
        if (w_push && !w_flush) r_fifo_mem[r_wr_ptr] <= {r_pipe_last[ROM_LATENCY-1], w_rom_q};
    end

    assign w_head        = r_fifo_mem[r_rd_ptr];
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_head[VEC_W-1:0] : '0;
    assign bus.out_last  = w_out_valid && w_head[VEC_W];
    assign bus.busy      = (r_state != c_idle) || w_accept;
    assign bus.done      = (r_state == c_done);

`ifdef MATRIX_FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles the consumer held off a valid vector.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                                r_stall_cnt <= '0;
        else if (w_accept)                                           r_stall_cnt <= '0;
        else if (w_out_valid && !bus.out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.stall_cycles = r_stall_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_matrix_stream_fetch                                     |
// | Description : Self-checking bench for matrix_stream_fetch. A queue-based |
// |               reference computes every expected vector from the address  |
// |               rules; directed and $urandom commands are streamed through.|
// |               Honours MATRIX_FETCH_STALL_CNT_EN for the stall counter.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_matrix_stream_fetch;
    localparam int DW    = 8;
    localparam int AW    = 14;
    localparam int LANES = 4;
    localparam int RL    = 1;
    localparam int FD    = 4;
    localparam int VW    = LANES * DW;

    typedef struct packed {
        logic [VW-1:0] data;
        logic          last;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    matrix_stream_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LANES)) bus ();

    matrix_stream_fetch #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .LANES       (LANES),
        .ROM_LATENCY (RL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t exp_q[$];
    int   cyc, xfers, first_valid, first_xfer, last_xfer, done_cyc, done_cnt, busy_cyc, stall_exp;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: lane l of a vector at addr holds ROM[(addr+l) mod 2**AW] = that address mod 2**DW.
    function automatic logic [VW-1:0] model_vec(input int unsigned addr);
        logic [VW-1:0] v;
        int unsigned   a;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            a = (addr + l) % (1 << AW);
            v[l*DW +: DW] = DW'(a % (1 << DW));
        end
        return v;
    endfunction

    task automatic push_expected(input int unsigned base, input int unsigned stride, input int unsigned cnt);
        vec_t e;
        for (int unsigned n = 0; n < cnt; n++) begin
            e.data = model_vec((base + n * stride) % (1 << AW));
            e.last = (n == cnt - 1);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Scoreboard step, called at the falling edge with inputs already settled.
    task automatic observe();
        if (bus.out_valid) begin
            if (!bus.out_ready) stall_exp++;
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", 1, 0);
            end else begin
                check_val("data", bus.out_data, exp_q[0].data);
                check_val("last", bus.out_last, exp_q[0].last);
                if (first_valid < 0) first_valid = cyc;
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    xfers++;
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                end
            end
        end
    endtask

    task automatic reset_stats();
        cyc = 0; xfers = 0; first_valid = -1; first_xfer = -1; last_xfer = -1;
        done_cyc = -1; done_cnt = 0; busy_cyc = 0; stall_exp = 0;
    endtask

    task automatic run_cmd(input int unsigned base, input int unsigned stride, input int unsigned cnt,
                           input int mode, input bit inject);
        bit finished;
        push_expected(base, stride, cnt);
        reset_stats();
        bus.base_addr = AW'(base);
        bus.stride    = AW'(stride);
        bus.count     = AW'(cnt);
        bus.start     = 1'b1;
        finished      = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            bus.out_ready = ready_for(mode, cyc);
            if (cyc == 1) begin
                bus.start     = inject;
                bus.count     = AW'(5);
                bus.base_addr = AW'(16'h0123);
            end
            if (cyc == 2) bus.start = 1'b0;
            @(negedge clock);
            observe();
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                finished = 1'b1;
            end
            tick();
        end
        bus.start = 1'b0;
        if (!finished) check_val("timeout", 1, 0);
        check_val("done_once", done_cnt, 1);
        check_val("xfer_count", xfers, cnt);
        check_val("queue_drained", exp_q.size(), 0);
        if (cnt == 0) begin
            check_val("busy_len_cnt0", busy_cyc, 2);
            check_val("no_valid_cnt0", first_valid < 0, 1);
        end else begin
            check_val("done_after_last", done_cyc > last_xfer, 1);
            check_val("busy_span", busy_cyc, done_cyc + 1);
            if (mode == 0) begin
                check_val("latency", first_valid, RL + 2);
                check_val("throughput", last_xfer - first_xfer, cnt - 1);
            end
        end
        exp_q.delete();
        @(negedge clock);
        check_val("idle_busy", bus.busy, 0);
        check_val("idle_done", bus.done, 0);
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_busy"},  bus.busy, 0);
        check_val({tag, "_done"},  bus.done, 0);
        check_val({tag, "_valid"}, bus.out_valid, 0);
        check_val({tag, "_last"},  bus.out_last, 0);
        check_val({tag, "_data"},  bus.out_data, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        bus.base_addr = '0; bus.stride = '0; bus.count = '0;
        reset_stats();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick();

        // Basic stream and address wrap cases.
        run_cmd(32'h10, 4, 3, 0, 1'b0);
        run_cmd(32'h3FFE, 1, 1, 0, 1'b0);
        run_cmd(32'h3FFF, 2, 2, 0, 1'b0);
        // Backpressure 1 high / 3 low.
        run_cmd(32'h200, 3, 8, 1, 1'b0);
        // Zero-length command with a start attempted while busy.
        run_cmd(32'h40, 1, 0, 0, 1'b1);
        // Start attempted while busy in a non-empty command.
        run_cmd(32'h80, 5, 4, 0, 1'b1);
        // Randomized commands and consumer.
        for (int r = 0; r < 8; r++) begin
            run_cmd($urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1),
                    $urandom_range(1, 12), (r % 2 == 0) ? 2 : 0, 1'(r % 3 == 0));
        end

        // Abort three cycles into a 16-vector command.
        reset_stats();
        bus.base_addr = '0; bus.stride = AW'(1); bus.count = AW'(16);
        bus.out_ready = 1'b1; bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            tick();
            bus.start = 1'b0;
        end
        bus.abort = 1'b1;
        @(negedge clock);
        tick();
        bus.abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_val("abort_valid", bus.out_valid, 0);
            check_val("abort_busy", bus.busy, 0);
            check_val("abort_done", bus.done, 0);
            tick();
        end
        run_cmd(0, 1, 1, 0, 1'b0);

        // abort together with start in IDLE drops the start.
        bus.base_addr = '0; bus.count = AW'(3); bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clock);
        check_val("abort_start_busy", bus.busy, 0);
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check_val("abort_start_valid", bus.out_valid, 0);
            check_val("abort_start_busyq", bus.busy, 0);
            tick();
        end

        // Stalled stream, then asynchronous reset between edges.
        push_expected(32'h20, 1, 8);
        reset_stats();
        bus.base_addr = AW'(32'h20); bus.stride = AW'(1); bus.count = AW'(8);
        bus.out_ready = 1'b0; bus.start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            observe();
            tick();
            bus.start = 1'b0;
        end
        @(negedge clock);
        check_val("stall_valid", bus.out_valid, 1);
`ifdef MATRIX_FETCH_STALL_CNT_EN
        check_val("stall_model", stall_exp, 5);
        check_val("stall_cycles", bus.stall_cycles, 32'(stall_exp));
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
`ifdef MATRIX_FETCH_STALL_CNT_EN
        check_val("async_reset_stall", bus.stall_cycles, 0);
`endif
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        run_cmd(32'h10, 4, 3, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
